// File: rtl/image_mem_writer.sv
// Write-side engine for the image BRAM: turns a valid/ready pixel stream into
// registered single-port write strobes, one frame per accepted start pulse.
module image_mem_writer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   frame_len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              err_short,
   output logic              err_long,
   output logic [ADDR_W:0]   wr_count
);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   cnt_nxt;
   logic              xfer;

   // Ready is a pure decode of the state so a pixel is taken on every valid cycle of CAPTURE.
   assign s_ready = (state == CAPTURE);
   assign xfer    = s_valid && s_ready;
   assign cnt_nxt = wr_count + (ADDR_W+1)'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_addr  <= '0;
         len       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         wr_count  <= '0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur_addr  <= base_addr;
                  len       <= frame_len;
                  wr_count  <= '0;
                  err_short <= 1'b0;
                  err_long  <= 1'b0;
                  if (frame_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= CAPTURE;
                     busy  <= 1'b1;
                  end
               end
            end
            CAPTURE: begin
               if (xfer) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= cur_addr;
                  wr_data  <= s_data;
                  wr_count <= cnt_nxt;
                  // Wrap at DEPTH, which need not be a power of two.
                  cur_addr <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
                  if (cnt_nxt == len) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     if (!s_last) err_long <= 1'b1;
                  end else if (s_last) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     err_short <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_mem_writer.sv
// Bench for image_mem_writer: directed test-plan frames with literal checks,
// then random stream/start/reset traffic checked each cycle against a frame model.
module tb_image_mem_writer;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   frame_len;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              s_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              err_short;
   logic              err_long;
   logic [ADDR_W:0]   wr_count;

   image_mem_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
      .err_short(err_short), .err_long(err_long), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame is (base, len); word k lands at (base+k) mod DEPTH.
   int   m_phase;      // 0 waiting for start, 1 taking words, 2 end-of-frame cycle
   int   m_base, m_len, m_cnt;
   bit   m_wr_en, m_done, m_es, m_el;
   int   m_wr_addr, m_wr_data;

   always @(posedge clk) begin
      m_wr_en = 1'b0;
      m_done  = 1'b0;
      if (rst) begin
         m_phase = 0; m_base = 0; m_len = 0; m_cnt = 0;
         m_wr_addr = 0; m_wr_data = 0; m_es = 0; m_el = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_base = int'(base_addr); m_len = int'(frame_len);
            m_cnt = 0; m_es = 0; m_el = 0;
            if (m_len == 0) begin m_phase = 2; m_done = 1'b1; end
            else m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (s_valid) begin
            m_wr_en   = 1'b1;
            m_wr_addr = (m_base + m_cnt) % DEPTH;
            m_wr_data = int'(s_data);
            m_cnt++;
            if (m_cnt == m_len) begin
               m_phase = 2; m_done = 1'b1; m_el = !s_last;
            end else if (s_last) begin
               m_phase = 2; m_done = 1'b1; m_es = 1'b1;
            end
         end
      end else begin
         m_phase = 0;
      end
   end

   // Write log and done counter feed the directed literal checks.
   logic [ADDR_W-1:0] log_addr[$];
   logic [DATA_W-1:0] log_data[$];
   int                done_cnt = 0;
   bit                chk_en = 1'b0;

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("s_ready", 32'(s_ready), 32'(m_phase == 1));
         chk("busy", 32'(busy), 32'(m_phase == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("wr_en", 32'(wr_en), 32'(m_wr_en));
         chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
         chk("wr_data", 32'(wr_data), 32'(m_wr_data));
         chk("err_short", 32'(err_short), 32'(m_es));
         chk("err_long", 32'(err_long), 32'(m_el));
         chk("wr_count", 32'(wr_count), 32'(m_cnt));
      end
      if (wr_en === 1'b1) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      done_cnt = 0;
   endtask

   task automatic start_frame(input int b, input int l);
      @(negedge clk);
      start = 1'b1; base_addr = ADDR_W'(b); frame_len = (ADDR_W+1)'(l); s_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic word(input int d, input bit last, input int gap);
      s_valid = 1'b0; s_last = 1'b0;
      repeat (gap) @(negedge clk);
      s_valid = 1'b1; s_data = DATA_W'(d); s_last = last;
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; frame_len = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      chk_en = 1'b1;
      idle(3);
      chk("reset wr_en", 32'(wr_en), 32'd0);
      chk("reset wr_count", 32'(wr_count), 32'd0);
      chk("reset s_ready", 32'(s_ready), 32'd0);
      rst = 1'b0;
      idle(2);

      // Basic frame
      clear_log();
      start_frame(16'h010, 4);
      word(8'hA1, 0, 0); word(8'hA2, 0, 0); word(8'hA3, 0, 0); word(8'hA4, 1, 0);
      idle(3);
      chk("basic writes", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
         chk("basic addr", 32'(log_addr[i]), 32'h010 + 32'(i));
         chk("basic data", 32'(log_data[i]), 32'hA1 + 32'(i));
      end
      chk("basic done", 32'(done_cnt), 32'd1);
      chk("basic count", 32'(wr_count), 32'd4);
      chk("basic errs", 32'({err_short, err_long}), 32'd0);

      // Backpressure gaps
      clear_log();
      start_frame(16'h010, 4);
      word(8'hA1, 0, 0); word(8'hA2, 0, 2); word(8'hA3, 0, 2); word(8'hA4, 1, 2);
      idle(3);
      chk("gap writes", 32'(log_addr.size()), 32'd4);
      if (log_addr.size() == 4) chk("gap last addr", 32'(log_addr[3]), 32'h013);
      chk("gap done", 32'(done_cnt), 32'd1);

      // Wrap-around
      clear_log();
      start_frame(1022, 4);
      for (int i = 0; i < 4; i++) word(i + 1, i == 3, 0);
      idle(3);
      chk("wrap writes", 32'(log_addr.size()), 32'd4);
      if (log_addr.size() == 4) begin
         chk("wrap a0", 32'(log_addr[0]), 32'd1022);
         chk("wrap a1", 32'(log_addr[1]), 32'd1023);
         chk("wrap a2", 32'(log_addr[2]), 32'd0);
         chk("wrap a3", 32'(log_addr[3]), 32'd1);
      end

      // Short frame
      clear_log();
      start_frame(16'h040, 5);
      word(8'h11, 0, 0); word(8'h12, 0, 0); word(8'h13, 1, 0);
      word(8'h14, 0, 0);
      idle(3);
      chk("short writes", 32'(log_addr.size()), 32'd3);
      chk("short err_short", 32'(err_short), 32'd1);
      chk("short err_long", 32'(err_long), 32'd0);
      chk("short count", 32'(wr_count), 32'd3);
      chk("short done", 32'(done_cnt), 32'd1);

      // Long frame
      clear_log();
      start_frame(16'h080, 3);
      word(8'h21, 0, 0); word(8'h22, 0, 0); word(8'h23, 0, 0);
      idle(3);
      chk("long writes", 32'(log_addr.size()), 32'd3);
      chk("long err_long", 32'(err_long), 32'd1);
      chk("long err_short", 32'(err_short), 32'd0);
      chk("long done", 32'(done_cnt), 32'd1);

      // Zero-length frame: done immediately after the accepting edge, no writes
      clear_log();
      start_frame(16'h0F0, 0);
      chk("zero done", 32'(done), 32'd1);
      chk("zero s_ready", 32'(s_ready), 32'd0);
      idle(3);
      chk("zero writes", 32'(log_addr.size()), 32'd0);
      chk("zero count", 32'(wr_count), 32'd0);

      // Start during capture is ignored
      clear_log();
      start_frame(16'h100, 4);
      word(8'h31, 0, 0);
      start = 1'b1; base_addr = ADDR_W'(16'h200); frame_len = (ADDR_W+1)'(1);
      word(8'h32, 0, 0);
      start = 1'b0;
      word(8'h33, 0, 0); word(8'h34, 1, 0);
      idle(3);
      chk("midstart writes", 32'(log_addr.size()), 32'd4);
      if (log_addr.size() == 4) chk("midstart addr", 32'(log_addr[3]), 32'h103);
      chk("midstart count", 32'(wr_count), 32'd4);

      // Reset mid-frame
      clear_log();
      start_frame(16'h050, 4);
      word(8'h41, 0, 0); word(8'h42, 0, 0);
      rst = 1'b1; s_valid = 1'b1; s_data = 8'h43;
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0;
      chk("rst wr_en", 32'(wr_en), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst count", 32'(wr_count), 32'd0);
      idle(3);
      chk("rst writes", 32'(log_addr.size()), 32'd2);
      chk("rst done", 32'(done_cnt), 32'd0);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         int sel;
         rst   = ($urandom % 300) == 0;
         start = ($urandom % 6) == 0;
         base_addr = ADDR_W'($urandom % DEPTH);
         sel = int'($urandom % 10);
         if (sel == 0)      frame_len = '0;
         else if (sel == 1) frame_len = (ADDR_W+1)'(DEPTH);
         else               frame_len = (ADDR_W+1)'(1 + $urandom % 8);
         s_valid = ($urandom % 3) != 0;
         s_data  = DATA_W'($urandom);
         s_last  = ($urandom % 7) == 0;
         @(negedge clk);
      end
      rst = 1'b0; start = 1'b0; s_valid = 1'b0;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
